// File: rtl/mxu_seq_ctrl.sv
// Job sequencer for an N x N MXFP8 systolic MAC array: clear, skewed feed, drain, result readout.
// Optional MXU_SEQ_ACCUM_EN adds an accum input that suppresses the accumulator clear for a job.
module mxu_seq_ctrl #(
  parameter int N        = 2,
  parameter int K_W      = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [K_W-1:0]            k_len,
`ifdef MXU_SEQ_ACCUM_EN
  input  logic                      accum,
`endif
  input  logic                      abort,
  output logic                      busy,
  output logic                      clear,
  output logic [N-1:0]              lane_en,
  output logic [N*K_W-1:0]          lane_k,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [$clog2(N*N)-1:0]    result_idx,
  output logic                      done
);

  localparam int TW = K_W + $clog2(N) + 1;
  localparam int IW = $clog2(N*N);
  localparam int DW = $clog2(N + PIPE_LAT) + 1;
  localparam logic [TW-1:0] T_OFFS     = TW'(N - 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(N - 2 + PIPE_LAT);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N * N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READ, S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [TW-1:0]  t_reg, t_next;
  logic [DW-1:0]  drain_reg, drain_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [K_W-1:0] k_reg, k_next;
  logic           clear_next;
  logic [N-1:0]       lane_en_next;
  logic [N*K_W-1:0]   lane_k_next;
`ifdef MXU_SEQ_ACCUM_EN
  logic           accum_reg, accum_next;
`endif

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    drain_next = drain_reg;
    idx_next   = idx_reg;
    k_next     = k_reg;
`ifdef MXU_SEQ_ACCUM_EN
    accum_next = accum_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_CLEAR;
          k_next     = k_len;
`ifdef MXU_SEQ_ACCUM_EN
          accum_next = accum;
`endif
        end
      end
      S_CLEAR: begin
        t_next     = '0;
        drain_next = '0;
        state_next = (k_reg != '0) ? S_FEED : S_DRAIN;
      end
      S_FEED: begin
        // last feed cycle is when the highest lane issues its final k
        if (t_reg == TW'(k_reg) + T_OFFS) begin
          state_next = S_DRAIN;
          drain_next = '0;
        end else begin
          t_next = t_reg + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          state_next = S_READ;
          idx_next   = '0;
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      S_READ: begin
        if (result_ready) begin
          if (idx_reg == IDX_LAST) state_next = S_DONE;
          else                     idx_next   = idx_reg + 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort && state_reg != S_IDLE) begin
      state_next = S_IDLE;
      t_next     = '0;
      drain_next = '0;
      idx_next   = '0;
    end
  end

`ifdef MXU_SEQ_ACCUM_EN
  assign clear_next = (state_next == S_CLEAR) && !accum_next;
`else
  assign clear_next = (state_next == S_CLEAR);
`endif

  // Lane i runs i cycles behind lane 0 so operands meet on the array diagonal.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      localparam logic [TW-1:0] LANE_OFFS = TW'(gi);
      assign lane_en_next[gi] = (state_next == S_FEED) && (t_next >= LANE_OFFS) &&
                                (t_next < LANE_OFFS + TW'(k_next));
      assign lane_k_next[gi*K_W +: K_W] = lane_en_next[gi] ? K_W'(t_next - LANE_OFFS) : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      t_reg        <= '0;
      drain_reg    <= '0;
      idx_reg      <= '0;
      k_reg        <= '0;
`ifdef MXU_SEQ_ACCUM_EN
      accum_reg    <= 1'b0;
`endif
      busy         <= 1'b0;
      clear        <= 1'b0;
      lane_en      <= '0;
      lane_k       <= '0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      done         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      t_reg        <= t_next;
      drain_reg    <= drain_next;
      idx_reg      <= idx_next;
      k_reg        <= k_next;
`ifdef MXU_SEQ_ACCUM_EN
      accum_reg    <= accum_next;
`endif
      busy         <= (state_next != S_IDLE);
      clear        <= clear_next;
      lane_en      <= lane_en_next;
      lane_k       <= lane_k_next;
      result_valid <= (state_next == S_READ);
      result_idx   <= (state_next == S_READ) ? idx_next : '0;
      done         <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_mxu_seq_ctrl.sv
// Self-checking bench for mxu_seq_ctrl: directed jobs plus randomized jobs against a cycle-timeline model.
module tb_mxu_seq_ctrl;
  localparam int N        = 2;
  localparam int K_W      = 8;
  localparam int PIPE_LAT = 3;
  localparam int NN       = N * N;
  localparam int IW       = $clog2(NN);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic result_ready = 1'b0;
  logic [K_W-1:0] k_len = '0;
`ifdef MXU_SEQ_ACCUM_EN
  logic accum = 1'b0;
`endif
  logic busy, clear, result_valid, done;
  logic [N-1:0] lane_en;
  logic [N*K_W-1:0] lane_k;
  logic [IW-1:0] result_idx;

  int tests = 0;
  int fails = 0;
  int job_no = 0;
  int cyc_now = 0;

  mxu_seq_ctrl #(.N(N), .K_W(K_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
`ifdef MXU_SEQ_ACCUM_EN
    .accum(accum),
`endif
    .abort(abort), .busy(busy), .clear(clear), .lane_en(lane_en), .lane_k(lane_k),
    .result_valid(result_valid), .result_ready(result_ready), .result_idx(result_idx),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s job=%0d cyc=%0d observed=%0h expected=%0h", tag, job_no, cyc_now, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_clear"}, clear, 0);
    chk({tag, "_lane_en"}, lane_en, 0);
    chk({tag, "_lane_k"}, lane_k, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_idx"}, result_idx, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // phase: 1 clear, 2 feed, 3 drain, 4 read, 5 done; t is the feed step number
  task automatic check_cycle(input int ph, input int t, input int kk, input int reads, input bit acc);
    logic [N-1:0] en;
    logic [N*K_W-1:0] lk;
    en = '0;
    lk = '0;
    for (int i = 0; i < N; i++) begin
      if (ph == 2 && t >= i && t < i + kk) begin
        en[i] = 1'b1;
        lk[i*K_W +: K_W] = K_W'(t - i);
      end
    end
    chk("busy", busy, 1);
    chk("clear", clear, (ph == 1 && !acc) ? 1 : 0);
    chk("lane_en", lane_en, en);
    chk("lane_k", lane_k, lk);
    chk("result_valid", result_valid, (ph == 4) ? 1 : 0);
    chk("result_idx", result_idx, (ph == 4) ? reads : 0);
    chk("done", done, (ph == 5) ? 1 : 0);
  endtask

  task automatic run_job(input int kk, input int ready_pct, input bit acc, input int kill_cyc,
                         input bit kill_rst, input int stall_idx, input int stall_len,
                         input bit spam, input bit keep_start, input bit idle_abort);
    int f_len, d_len, r0, reads, stall_left, ph, cyc;
    f_len = (kk > 0) ? kk + N - 1 : 0;
    d_len = N - 1 + PIPE_LAT;
    r0 = 2 + f_len + d_len;
    reads = 0;
    stall_left = stall_len;
    job_no++;
    $display("[TB] job %0d: K=%0d ready_pct=%0d accum=%0d kill_cyc=%0d kill_rst=%0d",
             job_no, kk, ready_pct, acc, kill_cyc, kill_rst);
    start = 1'b1;
    k_len = K_W'(kk);
`ifdef MXU_SEQ_ACCUM_EN
    accum = acc;
`endif
    abort = idle_abort;
    result_ready = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    for (cyc = 1; cyc < 2000; cyc++) begin
      cyc_now = cyc;
      if (cyc == 1)              ph = 1;
      else if (cyc < 2 + f_len)  ph = 2;
      else if (cyc < r0)         ph = 3;
      else if (reads < NN)       ph = 4;
      else                       ph = 5;
      check_cycle(ph, cyc - 2, kk, reads, acc);
      if (cyc == kill_cyc) begin
        start = 1'b0;
        if (kill_rst) rst_n = 1'b0;
        else          abort = 1'b1;
        step();
        rst_n = 1'b1;
        abort = 1'b0;
        check_idle("killed");
        return;
      end
      if (ph == 5) begin
        start = keep_start;
        step();
        check_idle("post_done");
        return;
      end
      if (ph == 4 && reads == stall_idx && stall_left > 0) begin
        result_ready = 1'b0;
        stall_left--;
      end else begin
        result_ready = ($urandom_range(99) < ready_pct);
      end
      start = (spam && (ph == 3 || ph == 4)) ? 1'($urandom_range(1)) : 1'b0;
      if (ph == 4 && result_ready) reads++;
      step();
    end
    chk("job_timeout", cyc, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    step();
    check_idle("reset");
    rst_n = 1'b1;
    step();
    check_idle("idle");

    run_job(3, 100, 0, 0, 0, -1, 0, 0, 0, 0);     // basic N=2 K=3 job
    run_job(3, 100, 0, 0, 0, 2, 3, 0, 0, 0);      // backpressure at idx 2
    run_job(0, 100, 0, 0, 0, -1, 0, 0, 0, 0);     // K=0 skips feed
    run_job(5, 100, 0, 3, 0, -1, 0, 0, 0, 0);     // abort at feed t=1
    run_job(3, 100, 0, 0, 0, -1, 0, 0, 0, 0);
    run_job(4, 60, 0, 0, 0, -1, 0, 1, 0, 0);      // start spam in drain/read
    run_job(3, 100, 0, 11, 1, -1, 0, 0, 0, 0);    // reset during read
    run_job(2, 100, 0, 0, 0, -1, 0, 0, 0, 1);     // abort in idle with start
    run_job(2, 100, 0, 0, 0, -1, 0, 0, 1, 0);     // start held through done
    run_job(1, 100, 0, 0, 0, -1, 0, 0, 0, 0);
    run_job(255, 100, 0, 0, 0, -1, 0, 0, 0, 0);   // max K
`ifdef MXU_SEQ_ACCUM_EN
    run_job(3, 100, 0, 0, 0, -1, 0, 0, 0, 0);
    run_job(3, 100, 1, 0, 0, -1, 0, 0, 0, 0);
`endif

    for (int j = 0; j < 20; j++) begin
      int kk, pct, kc;
      bit acc;
      kk = $urandom_range(12);
      pct = $urandom_range(100, 30);
      kc = ($urandom_range(3) == 0) ? $urandom_range(20, 1) : 0;
`ifdef MXU_SEQ_ACCUM_EN
      acc = 1'($urandom_range(1));
`else
      acc = 1'b0;
`endif
      run_job(kk, pct, acc, kc, 1'($urandom_range(1)), $urandom_range(NN - 1),
              $urandom_range(3), 1'($urandom_range(1)), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
